// File: rtl/fifo_interface_pkg.sv
// fifo_interface_pkg: shared defaults and sizing helpers for fifo_interface.
//   DEFAULT_NUM_BITS : default payload width
//   DEFAULT_DEPTH    : default number of storage entries
//   ptr_width()      : read/write pointer width, one extra MSB for wrap
package fifo_interface_pkg;

    localparam int unsigned DEFAULT_NUM_BITS = 16;
    localparam int unsigned DEFAULT_DEPTH    = 16;

    // The extra MSB separates full from empty when the address bits match.
    function automatic int unsigned ptr_width(input int unsigned entries);
        return $clog2(entries) + 1;
    endfunction

endpackage

// File: rtl/fifo_interface_mem.sv
// fifo_interface_mem: depth x num_bits storage for fifo_interface.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write payload
//   raddr  : read address
//   rdata  : read payload, asynchronous read
// Contents are never reset.
module fifo_interface_mem
    import fifo_interface_pkg::*;
#(
    parameter int unsigned num_bits = DEFAULT_NUM_BITS,
    parameter int unsigned depth    = DEFAULT_DEPTH,
    localparam int unsigned AW      = $clog2(depth)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [num_bits-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [num_bits-1:0] rdata
);

    logic [num_bits-1:0] mem_q [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_interface.sv
// fifo_interface: single-clock first-word-fall-through FIFO.
//   clk        : clock, all state on rising edge
//   reset      : synchronous active-high reset, clears pointers only
//   in_data    : write payload
//   in_enable  : producer offers in_data
//   in_ready   : FIFO not full
//   out_data   : oldest stored word
//   out_enable : FIFO not empty
//   out_ready  : consumer takes out_data
// Optional (macro FIFO_INTERFACE_STATUS_EN):
//   count      : current occupancy
//   full       : FIFO full
//   empty      : FIFO empty
module fifo_interface
    import fifo_interface_pkg::*;
#(
    parameter int unsigned num_bits = DEFAULT_NUM_BITS,
    parameter int unsigned depth    = DEFAULT_DEPTH,
    localparam int unsigned PW      = ptr_width(depth),
    localparam int unsigned CW      = $clog2(depth + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [num_bits-1:0] in_data,
    input  logic                in_enable,
    output logic                in_ready,
    output logic [num_bits-1:0] out_data,
    output logic                out_enable,
    input  logic                out_ready
`ifdef FIFO_INTERFACE_STATUS_EN
    ,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                empty
`endif
);

    localparam int unsigned AW = PW - 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full_w;
    logic          empty_w;
    logic          do_write;
    logic          do_read;

    assign empty_w  = (wr_ptr_q == rd_ptr_q);
    assign full_w   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign in_ready   = !full_w;
    assign out_enable = !empty_w;

    assign do_write = in_enable && in_ready;
    assign do_read  = out_enable && out_ready;

    // Power-of-two depth makes natural overflow the modulo 2*depth wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_interface_mem #(
        .num_bits (num_bits),
        .depth    (depth)
    ) u_mem (
        .clk   (clk),
        .we    (do_write && !reset),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (out_data)
    );

`ifdef FIFO_INTERFACE_STATUS_EN
    logic [PW-1:0] occ_w;
    assign occ_w = wr_ptr_q - rd_ptr_q;
    assign count = CW'(occ_w);
    assign full  = full_w;
    assign empty = empty_w;
`endif

endmodule

// File: tb/tb_fifo_interface.sv
// tb_fifo_interface: scoreboard bench for fifo_interface (16 x 16 default).
module tb_fifo_interface;

    localparam int unsigned NB = 16;
    localparam int unsigned DP = 16;

    logic          clk;
    logic          reset;
    logic [NB-1:0] in_data;
    logic          in_enable;
    logic          in_ready;
    logic [NB-1:0] out_data;
    logic          out_enable;
    logic          out_ready;
`ifdef FIFO_INTERFACE_STATUS_EN
    logic [4:0]    count;
    logic          full;
    logic          empty;
`endif

    fifo_interface #(
        .num_bits (NB),
        .depth    (DP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_enable  (in_enable),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_enable (out_enable),
        .out_ready  (out_ready)
`ifdef FIFO_INTERFACE_STATUS_EN
        ,
        .count      (count),
        .full       (full),
        .empty      (empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [NB-1:0] sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check DUT against the model, advance the model.
    task automatic cycle(input logic rst, input logic ie, input logic [NB-1:0] d, input logic ordy);
        bit wr, rd;
        @(negedge clk);
        reset     = rst;
        in_enable = ie;
        in_data   = d;
        out_ready = ordy;
        #1;
        check("in_ready",   32'(in_ready),   32'(sb.size() < DP));
        check("out_enable", 32'(out_enable), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("out_data", 32'(out_data), 32'(sb[0]));
        end
`ifdef FIFO_INTERFACE_STATUS_EN
        check("count", 32'(count), 32'(sb.size()));
        check("full",  32'(full),  32'(sb.size() == DP));
        check("empty", 32'(empty), 32'(sb.size() == 0));
`endif
        wr = ie && (sb.size() < DP);
        rd = ordy && (sb.size() != 0);
        @(posedge clk);
        if (rst) begin
            sb.delete();
        end else begin
            if (rd) void'(sb.pop_front());
            if (wr) sb.push_back(d);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_enable = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset then idle.
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Fill with 0x0001..0x0010, then offer 0xBEEF while full.
        for (int i = 1; i <= 16; i++) cycle(1'b0, 1'b1, NB'(i), 1'b0);
        cycle(1'b0, 1'b1, 16'hBEEF, 1'b0);
        #1;
        check("full_in_ready", 32'(in_ready), 32'h0);
        check("full_head", 32'(out_data), 32'h0001);

        // Drain in order.
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);
        #1;
        check("drained_out_enable", 32'(out_enable), 32'h0);

        // Streaming 100 words with both handshakes high.
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, NB'(16'h1000 + i), 1'b1);
        #1;
        check("stream_occ", 32'(out_enable), 32'h1);
        check("stream_tail", 32'(out_data), 32'h1063);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Full FIFO with read and write offered in the same cycle.
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, NB'(16'h2000 + i), 1'b0);
        cycle(1'b0, 1'b1, 16'hDEAD, 1'b1);
        #1;
        check("rw_full_in_ready", 32'(in_ready), 32'h1);
        check("rw_full_head", 32'(out_data), 32'h2001);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Reset mid-stream with a concurrent write.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, NB'(16'h3000 + i), 1'b0);
        cycle(1'b1, 1'b1, 16'h3333, 1'b1);
        #1;
        check("rst_out_enable", 32'(out_enable), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), NB'($urandom), 1'($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_interface.md
FIFO_INTERFACE -- requirements
Module: fifo_interface

Interface
REQ-001 SHALL have parameter num_bits, default 16: payload width in bits (legal 1..128).
REQ-002 SHALL have parameter depth, default 16: storage entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset; one clock and synchronous active-high reset are fixed for this block.
REQ-005 SHALL have port in_data, input, num_bits: write payload.
REQ-006 SHALL have port in_enable, input, 1: producer offers in_data this cycle.
REQ-007 SHALL have port in_ready, output, 1: FIFO accepts a word this cycle.
REQ-008 SHALL have port out_data, output, num_bits: head-of-queue payload.
REQ-009 SHALL have port out_enable, output, 1: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1: consumer takes out_data this cycle.

Function
REQ-011 SHALL accept a write on a rising edge only when in_enable and in_ready are both 1.
REQ-012 SHALL complete a read on a rising edge only when out_enable and out_ready are both 1.
REQ-013 SHALL drive in_ready = not full, combinationally from registered state only, independent of out_ready.
REQ-014 SHALL drive out_enable = not empty, and out_data = oldest stored word (first-word fall-through); out_data is don't-care while out_enable is 0.
REQ-015 SHALL have 1-cycle write-to-output latency: a word written at edge N gives out_enable=1 after edge N; no same-cycle bypass when empty.
REQ-016 SHALL preserve strict FIFO order, with no loss or duplication.
REQ-017 SHALL use read and write pointers of clog2(depth)+1 bits that wrap modulo 2*depth; empty when the pointers are equal; full when the low bits are equal and the MSBs differ.
REQ-018 SHALL on a simultaneous accepted read and write leave occupancy unchanged and advance both pointers.
REQ-019 SHALL when full refuse writes even if a read occurs in the same cycle, because in_ready is low.
REQ-020 SHALL ignore in_enable while in_ready is 0 and out_ready while out_enable is 0, with no state change.
REQ-021 SHALL hold out_data stable while out_enable=1 and out_ready=0.

Reset
REQ-022 SHALL while reset=1 at a rising edge clear both pointers, so that after the edge in_ready=1 and out_enable=0; storage contents are not cleared.
REQ-023 SHALL let reset override any concurrent read or write in the same cycle, including mid-stream, with all stored words discarded.

Configuration
REQ-024 SHALL when macro FIFO_INTERFACE_STATUS_EN is defined add outputs count (clog2(depth+1) bits, current occupancy), full and empty (1 bit each), all reset to 0/0/1.
REQ-025 SHALL when FIFO_INTERFACE_STATUS_EN is undefined omit these ports entirely, with identical core behaviour.

Structure
REQ-026 SHALL place the default constants (DEFAULT_NUM_BITS=16, DEFAULT_DEPTH=16) and a pointer-width helper function in package fifo_interface_pkg.
REQ-027 SHALL implement storage in one sub-module fifo_interface_mem: synchronous write, asynchronous read, depth x num_bits, no reset.
REQ-028 SHALL keep pointer, flag and handshake logic in fifo_interface.

Verification
REQ-029 Reset then idle -> in_ready=1, out_enable=0; with STATUS_EN, count=0 and empty=1.
REQ-030 Write 0x0001..0x0010 with out_ready=0 (depth 16) -> in_ready=0 after the 16th edge; a 17th offered word (0xBEEF) is not stored; out_data=0x0001.
REQ-031 Drain the full FIFO with out_ready=1 -> 0x0001..0x0010 read in order over 16 cycles; out_enable=0 after the last read.
REQ-032 Continuous write and read for 100 words with both handshakes held high -> occupancy constant after the first word; pointers wrap past 2*depth; all data in order.
REQ-033 Full FIFO with in_enable=1 and out_ready=1 for one cycle -> one word read, none written, count=15.
REQ-034 Assert reset with 5 words queued while in_enable=1 -> after the edge empty, out_enable=0, the concurrent write discarded.
